// File: rtl/coherence_arbiter_n.sv
// coherence_arbiter_n: N-core shared RAM port arbiter with snoop-based coherence.
// Data requests beat instruction fetches; within each class, grant is round-robin.
// A dirty copy found by a snoop is forwarded cache-to-cache and written back to RAM
// in the same transaction.
// Optional build macro COHERENCE_ARBITER_FIXED_PRIO_EN: both classes use fixed
// priority (lowest index wins) and the round-robin pointers are not built.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module coherence_arbiter_n
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 4,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*ADDR_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [WORD_W-1:0]      iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*ADDR_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [WORD_W-1:0]      dload,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        ccdirty,
    output logic [ADDR_W-1:0]      ccsnoopaddr,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  ramstate_t              ramstate
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SNOOP  = 3'd1;
    localparam logic [2:0] FWD    = 3'd2;
    localparam logic [2:0] RAMRD  = 3'd3;
    localparam logic [2:0] RAMWR  = 3'd4;
    localparam logic [2:0] IFETCH = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] d_pick, i_pick;
    logic [CPUS-1:0]  d_req;
    logic [CPUS-1:0]  others;
    logic [CPUS-1:0]  dirty_others;

    logic [ADDR_W-1:0] iaddr_a  [CPUS];
    logic [ADDR_W-1:0] daddr_a  [CPUS];
    logic [WORD_W-1:0] dstore_a [CPUS];

    // First requester at or after ptr, wrapping modulo CPUS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   idx;
        logic [IDX_W-1:0] res;
        res = ptr;
        for (int i = CPUS - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (idx >= (IDX_W + 1)'(CPUS)) idx = idx - (IDX_W + 1)'(CPUS);
            if (req[idx[IDX_W-1:0]]) res = idx[IDX_W-1:0];
        end
        return res;
    endfunction

    // Lowest set bit index; only meaningful when v is non-zero.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [CPUS-1:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    genvar k;
    generate
        for (k = 0; k < CPUS; k++) begin : g_unpack
            assign iaddr_a[k]  = iaddr[k*ADDR_W +: ADDR_W];
            assign daddr_a[k]  = daddr[k*ADDR_W +: ADDR_W];
            assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
        end
    endgenerate

    assign d_req        = dREN | dWEN;
    assign others       = ~(CPUS'(1) << grant_q);
    assign dirty_others = ccdirty & others;

`ifdef COHERENCE_ARBITER_FIXED_PRIO_EN
    assign d_pick = rr_pick(d_req, '0);
    assign i_pick = rr_pick(iREN, '0);
`else
    logic [IDX_W-1:0] dptr_q, dptr_d;
    logic [IDX_W-1:0] iptr_q, iptr_d;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(CPUS - 1)) ? '0 : g + 1'b1;
    endfunction

    assign d_pick = rr_pick(d_req, dptr_q);
    assign i_pick = rr_pick(iREN, iptr_q);
`endif

    // Next-state, grant bookkeeping and all combinational outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
        dptr_d      = dptr_q;
        iptr_d      = iptr_q;
`endif
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = ramload;
        dload       = ramload;

        case (state_q)
            IDLE: begin
                if (|d_req) begin
                    grant_d = d_pick;
                    state_d = dWEN[d_pick] ? RAMWR : SNOOP;
                end else if (|iREN) begin
                    grant_d = i_pick;
                    state_d = IFETCH;
                end
            end
            SNOOP: begin
                ccsnoopaddr = daddr_a[grant_q];
                ccwait      = others;
                ccinv       = ccwrite[grant_q] ? others : '0;
                if (|dirty_others) begin
                    owner_d = lowest_set(dirty_others);
                    state_d = FWD;
                end else begin
                    state_d = RAMRD;
                end
            end
            FWD: begin
                ccsnoopaddr = daddr_a[grant_q];
                ccwait      = others;
                dload       = dstore_a[owner_q];
                ramWEN      = 1'b1;
                ramaddr     = daddr_a[grant_q];
                ramstore    = dstore_a[owner_q];
                if (ramstate == ACCESS) begin
                    dwait[grant_q] = 1'b0;
                    state_d        = IDLE;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
                    dptr_d         = next_idx(grant_q);
`endif
                end
            end
            RAMRD: begin
                ramREN  = 1'b1;
                ramaddr = daddr_a[grant_q];
                if (ramstate == ACCESS) begin
                    dwait[grant_q] = 1'b0;
                    state_d        = IDLE;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
                    dptr_d         = next_idx(grant_q);
`endif
                end
            end
            RAMWR: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_a[grant_q];
                ramstore = dstore_a[grant_q];
                if (ramstate == ACCESS) begin
                    dwait[grant_q] = 1'b0;
                    state_d        = IDLE;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
                    dptr_d         = next_idx(grant_q);
`endif
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr_a[grant_q];
                if (ramstate == ACCESS) begin
                    iwait[grant_q] = 1'b0;
                    state_d        = IDLE;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
                    iptr_d         = next_idx(grant_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, owner and pointer registers with asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
            dptr_q  <= '0;
            iptr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
`ifndef COHERENCE_ARBITER_FIXED_PRIO_EN
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_coherence_arbiter_n.sv
// Testbench for coherence_arbiter_n: directed scenarios followed by randomized
// request sets, checked against a transaction-level reference model.
module tb_coherence_arbiter_n;
    import cpu_types_pkg::*;

    localparam int CPUS   = 4;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [CPUS-1:0]        iREN, dREN, dWEN, ccwrite, ccdirty;
    logic [CPUS*ADDR_W-1:0] iaddr, daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iwait, dwait, ccwait, ccinv;
    logic [WORD_W-1:0]      iload, dload, ramstore, ramload;
    logic [ADDR_W-1:0]      ccsnoopaddr, ramaddr;
    logic                   ramREN, ramWEN;
    ramstate_t              ramstate;

    logic [ADDR_W-1:0] ia [CPUS];
    logic [ADDR_W-1:0] da [CPUS];
    logic [WORD_W-1:0] ds [CPUS];
    logic [WORD_W-1:0] mem [256];

    int ram_lat;
    int ram_cnt;
    bit ram_err_en;
    int n_checks;
    int n_pass;
    int m_dptr;
    int m_iptr;

    coherence_arbiter_n #(.CPUS(CPUS), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .ccdirty(ccdirty), .ccsnoopaddr(ccsnoopaddr),
        .ccwait(ccwait), .ccinv(ccinv),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        iaddr  = '0;
        daddr  = '0;
        dstore = '0;
        for (int k = 0; k < CPUS; k++) begin
            iaddr[k*ADDR_W +: ADDR_W]  = ia[k];
            daddr[k*ADDR_W +: ADDR_W]  = da[k];
            dstore[k*WORD_W +: WORD_W] = ds[k];
        end
    end

    // RAM model: answers ACCESS after ram_lat busy cycles of a held strobe.
    assign ramload = mem[ramaddr[9:2]];
    always @(negedge CLK) begin
        if (nRST && (ramREN || ramWEN)) begin
            if (ram_cnt >= ram_lat) begin
                ramstate = ACCESS;
                if (ramWEN) mem[ramaddr[9:2]] = ramstore;
            end else begin
                ramstate = (ram_err_en && ($urandom_range(0, 1) == 1)) ? ERROR : BUSY;
            end
            ram_cnt++;
        end else begin
            ramstate = FREE;
            ram_cnt  = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
        int p;
`ifdef COHERENCE_ARBITER_FIXED_PRIO_EN
        p = 0;
`else
        p = ptr;
`endif
        for (int i = 0; i < CPUS; i++) begin
            if (req[(p + i) % CPUS]) return (p + i) % CPUS;
        end
        return -1;
    endfunction

    // One arbitrated transaction, started from IDLE right after a posedge.
    task automatic run_txn(input string tag);
        logic [CPUS-1:0]   dreq, oth, dirt, e_ccw, e_inv, e_iw, e_dw;
        logic [ADDR_W-1:0] a, e_snaddr, e_raddr;
        logic [WORD_W-1:0] w, e_rstore;
        bit is_data, is_wr, is_rd, fwd, snoop_ph, ram_ph, done, e_ren, e_wen;
        int g, own, exp_n;
        dreq    = dREN | dWEN;
        is_data = (dreq != '0);
        g       = is_data ? pick(dreq, m_dptr) : pick(iREN, m_iptr);
        if (g < 0) return;
        oth   = ~(CPUS'(1) << g);
        is_wr = is_data && dWEN[g];
        is_rd = is_data && !is_wr;
        dirt  = ccdirty & oth;
        own   = -1;
        for (int k = CPUS - 1; k >= 0; k--) if (dirt[k]) own = k;
        fwd   = is_rd && (own >= 0);
        a     = is_data ? da[g] : ia[g];
        if (fwd)        w = ds[own];
        else if (is_wr) w = ds[g];
        else            w = mem[a[9:2]];
        exp_n = (is_rd ? 3 : 2) + ram_lat;
        done  = 0;
        for (int n = 1; n <= exp_n + 4 && !done; n++) begin
            @(negedge CLK);
            #1;
            snoop_ph = is_rd && (n == 2);
            ram_ph   = (n >= (is_rd ? 3 : 2));
            e_ccw    = (snoop_ph || (ram_ph && fwd)) ? oth : '0;
            e_inv    = (snoop_ph && ccwrite[g]) ? oth : '0;
            e_snaddr = (e_ccw != '0) ? a : '0;
            e_ren    = ram_ph && !is_wr && !fwd;
            e_wen    = ram_ph && (is_wr || fwd);
            e_raddr  = ram_ph ? a : '0;
            e_rstore = e_wen ? w : '0;
            e_iw     = '1;
            e_dw     = '1;
            if (ram_ph && n == exp_n) begin
                if (is_data) e_dw[g] = 1'b0;
                else         e_iw[g] = 1'b0;
            end
            chk({tag, "_ccwait"}, ccwait, e_ccw);
            chk({tag, "_ccinv"}, ccinv, e_inv);
            chk({tag, "_snaddr"}, ccsnoopaddr, e_snaddr);
            chk({tag, "_strobes"}, {ramREN, ramWEN}, {e_ren, e_wen});
            chk({tag, "_ramaddr"}, ramaddr, e_raddr);
            chk({tag, "_ramstore"}, ramstore, e_rstore);
            chk({tag, "_waits"}, {iwait, dwait}, {e_iw, e_dw});
            chk({tag, "_onewait"}, 32'($countones(~{iwait, dwait}) <= 1), 32'd1);
            if (ram_ph && fwd) chk({tag, "_fwd_dload"}, dload, w);
            if ((iwait != '1) || (dwait != '1)) begin
                done = 1;
                if (is_rd)      chk({tag, "_dload"}, dload, w);
                else if (!is_data) chk({tag, "_iload"}, iload, w);
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        @(posedge CLK);
        #1;
        if (is_data) begin
            m_dptr  = (g + 1) % CPUS;
            dREN[g] = 1'b0;
            dWEN[g] = 1'b0;
        end else begin
            m_iptr  = (g + 1) % CPUS;
            iREN[g] = 1'b0;
        end
        if (is_wr || fwd) chk({tag, "_ramcontent"}, mem[a[9:2]], w);
    endtask

    task automatic check_defaults(input string tag);
        chk({tag, "_iwait"}, iwait, {CPUS{1'b1}});
        chk({tag, "_dwait"}, dwait, {CPUS{1'b1}});
        chk({tag, "_ccwait"}, ccwait, '0);
        chk({tag, "_ccinv"}, ccinv, '0);
        chk({tag, "_snaddr"}, ccsnoopaddr, '0);
        chk({tag, "_strobes"}, {ramREN, ramWEN}, 2'b00);
        chk({tag, "_ramaddr"}, ramaddr, '0);
        chk({tag, "_ramstore"}, ramstore, '0);
        chk({tag, "_dload"}, dload, ramload);
        chk({tag, "_iload"}, iload, ramload);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        m_dptr     = 0;
        m_iptr     = 0;
        ram_lat    = 0;
        ram_cnt    = 0;
        ram_err_en = 0;
        ramstate   = FREE;
        nRST       = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; ccdirty = '0;
        for (int k = 0; k < CPUS; k++) begin
            ia[k] = '0; da[k] = '0; ds[k] = '0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0007;

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        check_defaults("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Two data reads, round-robin from core 0, RAM two cycles busy
        ram_lat = 2;
        dREN[0] = 1'b1; da[0] = 32'h100;
        dREN[2] = 1'b1; da[2] = 32'h200;
        run_txn("rd_c0");
        run_txn("rd_c2");

        // Read-exclusive with a dirty copy in core 3
        ram_lat = 1;
        dREN[1] = 1'b1; da[1] = 32'h40; ccwrite[1] = 1'b1;
        ccdirty[3] = 1'b1; ds[3] = 32'hDEAD_BEEF;
        run_txn("fwd_c3");
        ccwrite = '0; ccdirty = '0;

        // Data write beats four instruction fetches
        ram_lat = 0;
        iREN = '1;
        for (int k = 0; k < CPUS; k++) ia[k] = 32'h800 + 32'(k) * 32'h14;
        dWEN[2] = 1'b1; da[2] = 32'h2C0; ds[2] = 32'hCAFE_0002;
        for (int t = 0; t < 5; t++) run_txn("wr_then_ifetch");

        // Two dirty snoopers: lowest index owns the line
        dREN[0] = 1'b1; da[0] = 32'h0A4;
        ccdirty = 4'b0110; ds[1] = 32'h1111_1111; ds[2] = 32'h2222_2222;
        run_txn("two_dirty");
        ccdirty = '0;

        // Read and write together from one core: the write wins
        dREN[1] = 1'b1; dWEN[1] = 1'b1; da[1] = 32'h3F0; ds[1] = 32'h0BAD_F00D;
        run_txn("ren_wen");

        // Asynchronous reset while forwarding
        ram_lat = 8;
        dREN[0] = 1'b1; da[0] = 32'h300;
        ccdirty = 4'b0100; ds[2] = 32'h5A5A_5A5A;
        repeat (3) @(negedge CLK);
        #1;
        chk("pre_reset_fwd_wen", {ramREN, ramWEN}, 2'b01);
        chk("pre_reset_fwd_dload", dload, 32'h5A5A_5A5A);
        #1;
        nRST = 1'b0;
        #1;
        check_defaults("async_reset");
        dREN = '0; ccdirty = '0;
        @(negedge CLK);
        nRST = 1'b1;
        m_dptr = 0;
        m_iptr = 0;
        @(posedge CLK);
        #1;
        ram_lat = 0;
        dREN = '1;
        for (int k = 0; k < CPUS; k++) da[k] = 32'h500 + 32'(k) * 32'h8;
        run_txn("post_reset_first");
        while (dREN != '0) run_txn("post_reset_rest");

        // Cores 0 and 3 fetching continuously
        for (int t = 0; t < 4; t++) begin
            iREN[0] = 1'b1; ia[0] = 32'h600;
            iREN[3] = 1'b1; ia[3] = 32'h6F0;
            run_txn("ifetch_0_3");
        end
        while (iREN != '0) run_txn("ifetch_drain");

        // Randomized request sets
        ram_err_en = 1;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < CPUS; k++) begin
                ia[k] = $urandom & 32'hFFFF_FFFC;
                da[k] = $urandom & 32'hFFFF_FFFC;
                ds[k] = $urandom;
            end
            iREN    = CPUS'($urandom);
            dREN    = CPUS'($urandom);
            dWEN    = CPUS'($urandom) & CPUS'($urandom);
            ccwrite = CPUS'($urandom);
            while ((iREN | dREN | dWEN) != '0) begin
                ccdirty = CPUS'($urandom) & CPUS'($urandom);
                ram_lat = $urandom_range(0, 3);
                run_txn("random");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
